// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ABORT = 2'd2,
      DRAIN = 2'd3
   } arb_state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_S0   = 2'b01;
   localparam logic [1:0] GRANT_S1   = 2'b10;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the pointer names the source that wins a tie.
module rr_arb2
   import eth_tx_arb_pkg::*;
(
   input  logic       axi_tclk,
   input  logic       axi_tresetn,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt_c
);

   logic ptr_q;

   always_comb begin
      gnt_c = GRANT_NONE;
      if (req == 2'b11) begin
         gnt_c = ptr_q ? GRANT_S1 : GRANT_S0;
      end else begin
         gnt_c = req;
      end
   end

   // After granting source 0 the tie goes to source 1 next time, and vice versa.
   always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
      if (!axi_tresetn) begin
         ptr_q <= 1'b0;
      end else if (accept && (gnt_c != GRANT_NONE)) begin
         ptr_q <= gnt_c[0];
      end
   end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin mux of two AXI-Stream sources onto the TX MAC.
// Define ETH_TX_ARB_TIMEOUT_EN to add the mid-frame stall watchdog (ABORT/DRAIN).
module eth_tx_frame_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic                  axi_tclk,
   input  logic                  axi_tresetn,
   input  logic                  enable_arb,
   input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
   input  logic                  s0_axis_tvalid,
   input  logic                  s0_axis_tlast,
   output logic                  s0_axis_tready,
   input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
   input  logic                  s1_axis_tvalid,
   input  logic                  s1_axis_tlast,
   output logic                  s1_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic [1:0]            grant,
   output logic [15:0]           frame_cnt0,
   output logic [15:0]           frame_cnt1,
   output logic                  abort_pulse
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be non-zero");
   end

   arb_state_e            state_q, state_d;
   logic [1:0]            grant_d;
   logic [1:0]            arb_gnt_c;
   logic                  arb_accept_c;
   logic                  inc0_c, inc1_c;
   logic [DATA_WIDTH-1:0] src_tdata_c;
   logic                  src_tvalid_c;
   logic                  src_tlast_c;

`ifdef ETH_TX_ARB_TIMEOUT_EN
   localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               seen_q, seen_d;
`endif

   rr_arb2 u_rr_arb2 (
      .axi_tclk    (axi_tclk),
      .axi_tresetn (axi_tresetn),
      .req         ({s1_axis_tvalid, s0_axis_tvalid}),
      .accept      (arb_accept_c),
      .gnt_c       (arb_gnt_c)
   );

   // Granted-source view; only consumed while a grant is held.
   assign src_tdata_c  = grant[1] ? s1_axis_tdata  : s0_axis_tdata;
   assign src_tvalid_c = grant[1] ? s1_axis_tvalid : s0_axis_tvalid;
   assign src_tlast_c  = grant[1] ? s1_axis_tlast  : s0_axis_tlast;

   always_comb begin
      state_d        = state_q;
      grant_d        = grant;
      arb_accept_c   = 1'b0;
      inc0_c         = 1'b0;
      inc1_c         = 1'b0;
      m_axis_tdata   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      m_axis_tuser   = 1'b0;
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
      stall_d        = stall_q;
      seen_d         = seen_q;
`endif
      case (state_q)
         IDLE: begin
            if (enable_arb && (s0_axis_tvalid || s1_axis_tvalid)) begin
               arb_accept_c = 1'b1;
               grant_d      = arb_gnt_c;
               state_d      = GRANT;
`ifdef ETH_TX_ARB_TIMEOUT_EN
               stall_d      = '0;
               seen_d       = 1'b0;
`endif
            end
         end
         GRANT: begin
            m_axis_tdata   = src_tdata_c;
            m_axis_tvalid  = src_tvalid_c;
            m_axis_tlast   = src_tlast_c;
            s0_axis_tready = grant[0] & m_axis_tready;
            s1_axis_tready = grant[1] & m_axis_tready;
            if (src_tvalid_c && m_axis_tready && src_tlast_c) begin
               inc0_c  = grant[0];
               inc1_c  = grant[1];
               grant_d = GRANT_NONE;
               state_d = IDLE;
            end
`ifdef ETH_TX_ARB_TIMEOUT_EN
            else if (src_tvalid_c) begin
               stall_d = '0;
               if (m_axis_tready) begin
                  seen_d = 1'b1;
               end
            end else if (seen_q) begin
               if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d = ABORT;
               end else begin
                  stall_d = stall_q + STALL_W'(1);
               end
            end
`endif
         end
`ifdef ETH_TX_ARB_TIMEOUT_EN
         // Close the truncated frame toward the MAC with an error-marked last beat.
         ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            s0_axis_tready = grant[0];
            s1_axis_tready = grant[1];
            if (src_tvalid_c && src_tlast_c) begin
               grant_d = GRANT_NONE;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
      if (!axi_tresetn) begin
         state_q    <= IDLE;
         grant      <= GRANT_NONE;
         frame_cnt0 <= '0;
         frame_cnt1 <= '0;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
         if (inc0_c) begin
            frame_cnt0 <= frame_cnt0 + 16'd1;
         end
         if (inc1_c) begin
            frame_cnt1 <= frame_cnt1 + 16'd1;
         end
      end
   end

`ifdef ETH_TX_ARB_TIMEOUT_EN
   always_ff @(posedge axi_tclk or negedge axi_tresetn) begin
      if (!axi_tresetn) begin
         stall_q     <= '0;
         seen_q      <= 1'b0;
         abort_pulse <= 1'b0;
      end else begin
         stall_q     <= stall_d;
         seen_q      <= seen_d;
         abort_pulse <= (state_d == ABORT) && (state_q != ABORT);
      end
   end
`else
   assign abort_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized bench for eth_tx_frame_arbiter against a frame-queue reference model.
module tb_eth_tx_frame_arbiter;

`ifdef ETH_TX_ARB_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 8;
`else
   localparam int unsigned TB_TIMEOUT = 1024;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic        axi_tclk = 1'b0;
   logic        axi_tresetn;
   logic        enable_arb;
   logic [7:0]  s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
   logic        s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
   logic        s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
   logic [1:0]  grant;
   logic [15:0] frame_cnt0, frame_cnt1;
   logic        abort_pulse;

   logic        src_v [2];
   logic [7:0]  src_d [2];
   logic        src_l [2];

   assign s0_axis_tvalid = src_v[0];
   assign s0_axis_tdata  = src_d[0];
   assign s0_axis_tlast  = src_l[0];
   assign s1_axis_tvalid = src_v[1];
   assign s1_axis_tdata  = src_d[1];
   assign s1_axis_tlast  = src_l[1];

   eth_tx_frame_arbiter #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .axi_tclk       (axi_tclk),
      .axi_tresetn    (axi_tresetn),
      .enable_arb     (enable_arb),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tlast  (s0_axis_tlast),
      .s0_axis_tready (s0_axis_tready),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tlast  (s1_axis_tlast),
      .s1_axis_tready (s1_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tready  (m_axis_tready),
      .grant          (grant),
      .frame_cnt0     (frame_cnt0),
      .frame_cnt1     (frame_cnt1),
      .abort_pulse    (abort_pulse)
   );

   always #5 axi_tclk = ~axi_tclk;

   int    checks = 0;
   int    errors = 0;

   // Stimulus and reference model state
   beat_t drv_q [2][$];
   beat_t exp_q [2][$];
   bit    fs [2];
   int    gap_run [2];
   bit    h [2];
   bit    hm;
   int    gap_pct;
   int    mr_mode;
   bit    stall0;
   int    last_owner;
   int    cnt_m [2];
   bit    mon_in_frame;
   int    mon_owner;
   bit    idle_expect;
   int    exp_next;
   bit    raw_mode;
   int    raw_beats0;
   int    ab_cnt;
   int    beats_out;
   int    owner_seq [$];

   function automatic logic [1:0] onehot(input int o);
      return (o == 0) ? 2'b01 : 2'b10;
   endfunction

   // Round-robin over sources holding unsent frames; the other source wins a tie.
   function automatic int pick_owner();
      bit p0 = exp_q[0].size() > 0;
      bit p1 = exp_q[1].size() > 0;
      if (p0 && p1) return 1 - last_owner;
      return p0 ? 0 : 1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         drv_q[s].delete();
         exp_q[s].delete();
         fs[s] = 1'b1;
         gap_run[s] = 0;
         h[s] = 1'b0;
         src_v[s] = 1'b0;
         src_d[s] = 8'h00;
         src_l[s] = 1'b0;
         cnt_m[s] = 0;
      end
      last_owner = 1;
      mon_in_frame = 1'b0;
      idle_expect = 1'b0;
      exp_next = -1;
      stall0 = 1'b0;
      owner_seq.delete();
   endtask

   task automatic add_frame(input int s, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = 8'($urandom);
         b.l = (i == len - 1);
         drv_q[s].push_back(b);
         exp_q[s].push_back(b);
      end
   endtask

   task automatic drive_inputs();
      for (int s = 0; s < 2; s++) begin
         if (!(src_v[s] && !h[s])) begin
            if (drv_q[s].size() == 0 || (s == 0 && stall0)) begin
               src_v[s] = 1'b0;
            end else if (fs[s] || gap_run[s] >= 3 || int'($urandom_range(99, 0)) >= gap_pct) begin
               src_v[s] = 1'b1;
               src_d[s] = drv_q[s][0].d;
               src_l[s] = drv_q[s][0].l;
               gap_run[s] = 0;
            end else begin
               src_v[s] = 1'b0;
               gap_run[s]++;
            end
         end
      end
      case (mr_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = ~m_axis_tready;
         default: m_axis_tready = 1'($urandom_range(1, 0));
      endcase
   endtask

   task automatic monitor_beat();
      beat_t b;
      if (!mon_in_frame) begin
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %h with no frame pending", m_axis_tdata);
            return;
         end
         mon_owner = pick_owner();
         mon_in_frame = 1'b1;
         owner_seq.push_back(mon_owner);
         checks++;
         if (grant !== onehot(mon_owner)) begin
            errors++;
            $display("FAIL frame_owner: got grant %b expected %b", grant, onehot(mon_owner));
         end
      end
      b = exp_q[mon_owner].pop_front();
      beats_out++;
      checks++;
      if (m_axis_tdata !== b.d || m_axis_tlast !== b.l || m_axis_tuser !== 1'b0) begin
         errors++;
         $display("FAIL beat_data: got d=%h l=%b u=%b expected d=%h l=%b u=0",
                  m_axis_tdata, m_axis_tlast, m_axis_tuser, b.d, b.l);
      end
      if (b.l) begin
         mon_in_frame = 1'b0;
         last_owner = mon_owner;
         cnt_m[mon_owner]++;
         idle_expect = 1'b1;
      end
   endtask

   // One clock: sample at the falling edge, then update stimulus just after the rising edge.
   task automatic step();
      beat_t b;
      @(negedge axi_tclk);
      h[0] = s0_axis_tvalid && s0_axis_tready;
      h[1] = s1_axis_tvalid && s1_axis_tready;
      hm   = m_axis_tvalid && m_axis_tready;
      if (raw_mode) begin
         if (h[0]) raw_beats0++;
         if (abort_pulse === 1'b1) ab_cnt++;
      end else begin
         if (exp_next >= 0) begin
            checks++;
            if (grant !== onehot(exp_next)) begin
               errors++;
               $display("FAIL next_grant: got %b expected %b", grant, onehot(exp_next));
            end
            exp_next = -1;
         end
         if (idle_expect) begin
            checks++;
            if (grant !== 2'b00 || m_axis_tvalid !== 1'b0 || s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0) begin
               errors++;
               $display("FAIL idle_gap: got grant=%b mv=%b r0=%b r1=%b expected all 0",
                        grant, m_axis_tvalid, s0_axis_tready, s1_axis_tready);
            end
            idle_expect = 1'b0;
            if (enable_arb && (exp_q[0].size() > 0 || exp_q[1].size() > 0)) exp_next = pick_owner();
         end
         if (mon_in_frame) begin
            checks++;
            if (s0_axis_tready !== (mon_owner == 0 && m_axis_tready) ||
                s1_axis_tready !== (mon_owner == 1 && m_axis_tready)) begin
               errors++;
               $display("FAIL tready_mirror: got r0=%b r1=%b owner=%0d m_tready=%b",
                        s0_axis_tready, s1_axis_tready, mon_owner, m_axis_tready);
            end
         end
         if (hm) monitor_beat();
      end
      @(posedge axi_tclk);
      #1;
      for (int s = 0; s < 2; s++) begin
         if (h[s] && drv_q[s].size() > 0) begin
            b = drv_q[s].pop_front();
            fs[s] = b.l;
         end
      end
      drive_inputs();
      h[0] = 1'b0;
      h[1] = 1'b0;
   endtask

   task automatic run_drain(input string name, input int max_cycles);
      int n = 0;
      while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && n < max_cycles) begin
         step();
         n++;
      end
      if (n >= max_cycles) begin
         errors++;
         $display("FAIL %s_timeout: got %0d beats left expected 0", name, exp_q[0].size() + exp_q[1].size());
      end
      step();
   endtask

   task automatic check_counters(input string name);
      checks++;
      if (frame_cnt0 !== 16'(cnt_m[0]) || frame_cnt1 !== 16'(cnt_m[1])) begin
         errors++;
         $display("FAIL %s_counters: got %0d/%0d expected %0d/%0d", name, frame_cnt0, frame_cnt1, cnt_m[0], cnt_m[1]);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0 || grant !== 2'b00 ||
          s0_axis_tready !== 1'b0 || s1_axis_tready !== 1'b0 || frame_cnt0 !== 16'd0 ||
          frame_cnt1 !== 16'd0 || abort_pulse !== 1'b0) begin
         errors++;
         $display("FAIL %s: got mv=%b ml=%b mu=%b g=%b r0=%b r1=%b c0=%0d c1=%0d ab=%b expected all 0", name,
                  m_axis_tvalid, m_axis_tlast, m_axis_tuser, grant, s0_axis_tready, s1_axis_tready,
                  frame_cnt0, frame_cnt1, abort_pulse);
      end
   endtask

   task automatic test_reset();
      model_reset();
      raw_mode = 1'b0;
      enable_arb = 1'b1;
      m_axis_tready = 1'b1;
      axi_tresetn = 1'b0;
      #1;
      check_all_zero("reset_state");
      repeat (2) @(posedge axi_tclk);
      #1;
      axi_tresetn = 1'b1;
      step();
      check_all_zero("post_reset_idle");
   endtask

   task automatic test_single_s1();
      int b0 = beats_out;
      mr_mode = 0; gap_pct = 0;
      add_frame(1, 64);
      drive_inputs();
      run_drain("single_s1", 200);
      checks++;
      if (beats_out - b0 != 64) begin
         errors++;
         $display("FAIL single_s1_beats: got %0d expected 64", beats_out - b0);
      end
      checks++;
      if (frame_cnt1 !== 16'd1) begin
         errors++;
         $display("FAIL single_s1_cnt1: got %0d expected 1", frame_cnt1);
      end
      check_counters("single_s1");
   endtask

   task automatic test_back_to_back();
      mr_mode = 0; gap_pct = 0;
      owner_seq.delete();
      for (int i = 0; i < 4; i++) begin
         add_frame(0, 16);
         add_frame(1, 16);
      end
      drive_inputs();
      run_drain("back_to_back", 400);
      checks++;
      if (owner_seq.size() != 8) begin
         errors++;
         $display("FAIL b2b_frames: got %0d expected 8", owner_seq.size());
      end
      for (int i = 0; i < owner_seq.size(); i++) begin
         checks++;
         if (owner_seq[i] != (i % 2)) begin
            errors++;
            $display("FAIL b2b_order: frame %0d got source %0d expected %0d", i, owner_seq[i], i % 2);
         end
      end
      check_counters("back_to_back");
   endtask

   task automatic test_tready_toggle();
      mr_mode = 1; gap_pct = 0;
      for (int i = 0; i < 3; i++) add_frame(0, int'($urandom_range(20, 2)));
      for (int i = 0; i < 2; i++) add_frame(1, int'($urandom_range(20, 2)));
      drive_inputs();
      run_drain("tready_toggle", 1000);
      check_counters("tready_toggle");
   endtask

   task automatic test_enable_drop();
      int b0;
      int n = 0;
      mr_mode = 0; gap_pct = 0;
      add_frame(0, 40);
      drive_inputs();
      b0 = beats_out;
      while (beats_out - b0 < 10 && n < 100) begin
         step();
         n++;
      end
      enable_arb = 1'b0;
      add_frame(1, 8);
      drive_inputs();
      n = 0;
      while (exp_q[0].size() > 0 && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (beats_out - b0 != 40) begin
         errors++;
         $display("FAIL enable_drop_beats: got %0d expected 40", beats_out - b0);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (grant !== 2'b00 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_hold: got grant=%b mv=%b expected 00/0", grant, m_axis_tvalid);
         end
      end
      enable_arb = 1'b1;
      run_drain("enable_drop", 200);
      check_counters("enable_drop");
   endtask

   task automatic test_random();
      mr_mode = 2; gap_pct = 30;
      add_frame(0, 1);
      add_frame(1, 1);
      for (int i = 0; i < 6; i++) begin
         add_frame(0, int'($urandom_range(20, 1)));
         add_frame(1, int'($urandom_range(20, 1)));
      end
      drive_inputs();
      run_drain("random", 5000);
      check_counters("random");
   endtask

   task automatic test_reset_midframe();
      int n = 0;
      int b0;
      mr_mode = 0; gap_pct = 0;
      add_frame(0, 30);
      drive_inputs();
      b0 = beats_out;
      while (beats_out - b0 < 7 && n < 100) begin
         step();
         n++;
      end
      #2;
      axi_tresetn = 1'b0;
      #1;
      check_all_zero("reset_midframe");
      model_reset();
      repeat (2) @(posedge axi_tclk);
      #1;
      axi_tresetn = 1'b1;
      add_frame(1, 5);
      add_frame(0, 5);
      drive_inputs();
      run_drain("after_reset", 200);
      checks++;
      if (owner_seq.size() != 2 || owner_seq[0] != 0) begin
         errors++;
         $display("FAIL after_reset_order: got %0d frames first source %0d expected 2 frames first 0",
                  owner_seq.size(), (owner_seq.size() > 0) ? owner_seq[0] : -1);
      end
      check_counters("after_reset");
   endtask

`ifdef ETH_TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      logic [15:0] cnt0_before;
      bit bad_drain = 1'b0;
      raw_mode = 1'b1;
      raw_beats0 = 0;
      ab_cnt = 0;
      mr_mode = 0; gap_pct = 0;
      cnt0_before = frame_cnt0;
      add_frame(0, 12);
      drive_inputs();
      while (raw_beats0 < 5 && n < 50) begin
         step();
         n++;
      end
      stall0 = 1'b1;
      src_v[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (m_axis_tvalid !== 1'b0 || grant !== 2'b01 || abort_pulse !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got mv=%b g=%b ab=%b expected 0/01/0", i, m_axis_tvalid, grant, abort_pulse);
         end
      end
      step();
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tuser !== 1'b1 ||
          m_axis_tdata !== 8'h00 || abort_pulse !== 1'b1) begin
         errors++;
         $display("FAIL abort_beat: got mv=%b ml=%b mu=%b d=%h ab=%b expected 1/1/1/00/1",
                  m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, abort_pulse);
      end
      step();
      checks++;
      if (m_axis_tvalid !== 1'b0 || abort_pulse !== 1'b0 || s0_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL drain_entry: got mv=%b ab=%b r0=%b expected 0/0/1", m_axis_tvalid, abort_pulse, s0_axis_tready);
      end
      stall0 = 1'b0;
      drive_inputs();
      n = 0;
      while (drv_q[0].size() > 0 && n < 100) begin
         step();
         if (m_axis_tvalid !== 1'b0) bad_drain = 1'b1;
         n++;
      end
      step();
      checks++;
      if (bad_drain || drv_q[0].size() != 0 || grant !== 2'b00) begin
         errors++;
         $display("FAIL drain_done: got left=%0d g=%b mv_seen=%b expected 0/00/0", drv_q[0].size(), grant, bad_drain);
      end
      checks++;
      if (frame_cnt0 !== cnt0_before || ab_cnt != 1) begin
         errors++;
         $display("FAIL abort_count: got cnt0=%0d pulses=%0d expected %0d/1", frame_cnt0, ab_cnt, cnt0_before);
      end
      exp_q[0].delete();
      last_owner = 0;
      raw_mode = 1'b0;
   endtask
`endif

   initial begin
      beats_out = 0;
      gap_pct = 0;
      mr_mode = 0;
      test_reset();
      test_single_s1();
      test_back_to_back();
      test_tready_toggle();
      test_enable_drop();
      test_random();
      test_reset_midframe();
`ifdef ETH_TX_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
